// File: rtl/surf_autotrain_sequencer.sv
// Per-SURF autotrain sequencer: seven training FSMs sharing one round-robin arbitrated COUT/DOUT alignment engine.
// Optional build macro SURF_AUTOTRAIN_RETRY_EN requeues failed alignments up to MAX_RETRY times before FAIL.
module surf_autotrain_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic [6:0]  enable_i,
  input  logic [6:0]  trainin_req_i,
  input  logic [6:0]  trainout_rdy_i,
  input  logic [6:0]  surf_live_i,
  output logic [6:0]  cin_train_o,
  output logic [6:0]  train_complete_o,
  output logic        align_req_o,
  output logic [2:0]  align_sel_o,
  input  logic        align_done_i,
  input  logic        align_ok_i,
  output logic [6:0]  fail_o,
  output logic [20:0] state_o
);

  localparam int unsigned N  = 7;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_CIN_TRAIN  = 3'd1,
    ST_WAIT_ALIGN = 3'd2,
    ST_ALIGNING   = 3'd3,
    ST_COMPLETE   = 3'd4,
    ST_LIVE       = 3'd5,
    ST_FAIL       = 3'd6
  } state_t;

  if (MAX_RETRY > 3) begin : g_max_retry_range
    $error("MAX_RETRY exceeds the 2-bit retry counter");
  end

  state_t          st_q [N];
  state_t          st_d [N];
  logic [TW-1:0]   tmo_q [N];
  logic [2:0]      ptr_q;
  logic            req_prev_q;
  logic [N-1:0]    elig;
  logic            gnt_vld;
  logic [2:0]      gnt_idx;
  logic [2:0]      cand;
  logic            done_v;
`ifdef SURF_AUTOTRAIN_RETRY_EN
  logic [1:0]      rty_q [N];
  logic [1:0]      rty_d [N];
`endif

  assign done_v = align_req_o && align_done_i;

  // Round-robin pick from ptr+1 upward; an aborting SURF is not eligible.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = ptr_q;
    cand    = '0;
    for (int i = 0; i < int'(N); i++) begin
      elig[i] = (st_q[i] == ST_WAIT_ALIGN) && enable_i[i] && trainin_req_i[i];
    end
    if (!align_req_o && !req_prev_q) begin
      for (int k = 1; k <= int'(N); k++) begin
        cand = 3'((int'(ptr_q) + k) % int'(N));
        if (!gnt_vld && elig[cand]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      st_d[i] = st_q[i];
`ifdef SURF_AUTOTRAIN_RETRY_EN
      rty_d[i] = rty_q[i];
`endif
      case (st_q[i])
        ST_IDLE:       if (enable_i[i] && trainin_req_i[i]) st_d[i] = ST_CIN_TRAIN;
        ST_CIN_TRAIN: begin
          if (trainout_rdy_i[i])                           st_d[i] = ST_WAIT_ALIGN;
          else if (tmo_q[i] == TW'(TIMEOUT_CYCLES - 1))    st_d[i] = ST_FAIL;
        end
        ST_WAIT_ALIGN: if (gnt_vld && gnt_idx == 3'(i))    st_d[i] = ST_ALIGNING;
        ST_ALIGNING: begin
          if (done_v && align_sel_o == 3'(i)) begin
            if (align_ok_i) st_d[i] = ST_COMPLETE;
`ifdef SURF_AUTOTRAIN_RETRY_EN
            else if (rty_q[i] < 2'(MAX_RETRY)) begin
              rty_d[i] = rty_q[i] + 2'd1;
              st_d[i]  = ST_WAIT_ALIGN;
            end
`endif
            else st_d[i] = ST_FAIL;
          end
        end
        ST_COMPLETE: begin
          if (surf_live_i[i])                              st_d[i] = ST_LIVE;
          else if (tmo_q[i] == TW'(TIMEOUT_CYCLES - 1))    st_d[i] = ST_FAIL;
        end
        ST_LIVE:       if (!surf_live_i[i])                st_d[i] = ST_IDLE;
        ST_FAIL:       if (!trainin_req_i[i])              st_d[i] = ST_IDLE;
        default:                                           st_d[i] = ST_IDLE;
      endcase
      // Abort overrides every other transition.
      if (!enable_i[i]) begin
        st_d[i] = ST_IDLE;
      end else if (!trainin_req_i[i] &&
                   (st_q[i] inside {ST_CIN_TRAIN, ST_WAIT_ALIGN, ST_ALIGNING, ST_COMPLETE})) begin
        st_d[i] = ST_IDLE;
      end
`ifdef SURF_AUTOTRAIN_RETRY_EN
      if (st_d[i] == ST_IDLE) rty_d[i] = '0;
`endif
    end
  end

  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      state_o[3*i +: 3] = st_q[i];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      for (int i = 0; i < int'(N); i++) begin
        st_q[i]  <= ST_IDLE;
        tmo_q[i] <= '0;
`ifdef SURF_AUTOTRAIN_RETRY_EN
        rty_q[i] <= '0;
`endif
      end
      cin_train_o      <= '0;
      train_complete_o <= '0;
      fail_o           <= '0;
      align_req_o      <= 1'b0;
      align_sel_o      <= '0;
      ptr_q            <= 3'd6;
      req_prev_q       <= 1'b0;
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        st_q[i] <= st_d[i];
`ifdef SURF_AUTOTRAIN_RETRY_EN
        rty_q[i] <= rty_d[i];
`endif
        // Timeout age restarts on any state change and saturates.
        if (st_d[i] != st_q[i]) begin
          tmo_q[i] <= '0;
        end else if ((st_q[i] == ST_CIN_TRAIN || st_q[i] == ST_COMPLETE) && tmo_q[i] != '1) begin
          tmo_q[i] <= tmo_q[i] + TW'(1);
        end
        cin_train_o[i]      <= st_d[i] inside {ST_CIN_TRAIN, ST_WAIT_ALIGN, ST_ALIGNING};
        train_complete_o[i] <= st_d[i] inside {ST_COMPLETE, ST_LIVE};
        fail_o[i]           <= (st_d[i] == ST_FAIL);
      end
      if (gnt_vld) begin
        align_sel_o <= gnt_idx;
        ptr_q       <= gnt_idx;
        align_req_o <= 1'b1;
      end else if (done_v) begin
        align_req_o <= 1'b0;
      end
      req_prev_q <= align_req_o;
    end
  end

endmodule

// File: doc/surf_autotrain_sequencer.md
Name: surf_autotrain_sequencer

Overview:
- Wbclk-domain consumer of the SURF live detector's trainin_req/trainout_rdy/surf_live vectors.
- Runs one training FSM per SURF (7 total):
  - puts that SURF's CIN into training mode;
  - arbitrates a single shared COUT/DOUT alignment engine;
  - returns train_complete to the live detector;
  - tracks the SURF until it goes live.
- Reports per-SURF state and failure to the register space.

Parameters:
TIMEOUT_CYCLES, 1000000, wbclk cycles allowed in CIN_TRAIN (waiting trainout_rdy) or COMPLETE (waiting surf_live) before FAIL
MAX_RETRY, 3, alignment retries before FAIL (used only with SURF_AUTOTRAIN_RETRY_EN)

Ports:
wb_clk_i  in  1  sole clock
wb_rst_n_i  in  1  synchronous, active-low reset
enable_i  in  7  per-SURF autotrain enable (register bit)
trainin_req_i  in  7  from live detector, wbclk-synchronized
trainout_rdy_i  in  7  from live detector
surf_live_i  in  7  from live detector
cin_train_o  out  7  force SURF CIN into training pattern
train_complete_o  out  7  to live detector train_complete_i
align_req_o  out  1  request to shared alignment engine
align_sel_o  out  3  SURF index being aligned (0-6)
align_done_i  in  1  one-cycle pulse, alignment finished
align_ok_i  in  1  alignment result, valid with align_done_i
fail_o  out  7  SURF i in FAIL
state_o  out  21  3-bit state per SURF, SURF i at [3i+:3]

Behaviour:
- Reset (wb_rst_n_i=0 at clock edge):
  - all FSMs go to IDLE;
  - every output is 0;
  - round-robin pointer goes to 6, so SURF 0 has first priority;
  - timeout and retry counters clear.
- State encoding: IDLE=0, CIN_TRAIN=1, WAIT_ALIGN=2, ALIGNING=3, COMPLETE=4, LIVE=5, FAIL=6.
- Per SURF i, registered transitions:
  - IDLE: if enable_i[i] && trainin_req_i[i], go to CIN_TRAIN next cycle.
  - CIN_TRAIN: if trainout_rdy_i[i], go to WAIT_ALIGN. Otherwise, when the timeout counter reaches TIMEOUT_CYCLES-1, go to FAIL.
  - WAIT_ALIGN: when granted, go to ALIGNING. No timeout.
  - ALIGNING: on align_done_i:
    - align_ok_i=1: go to COMPLETE;
    - align_ok_i=0: go to FAIL (see Optional Feature).
  - COMPLETE: if surf_live_i[i], go to LIVE. Otherwise go to FAIL on timeout, same rule as CIN_TRAIN.
  - LIVE: if surf_live_i[i]=0, go to IDLE.
  - FAIL: stays until trainin_req_i[i]=0, then goes to IDLE.
- Abort:
  - In CIN_TRAIN, WAIT_ALIGN, ALIGNING or COMPLETE, trainin_req_i[i]=0 sends the FSM to IDLE next cycle.
  - enable_i[i]=0 forces IDLE from any state.
  - Abort has priority over all other transitions.
- Outputs, all registered:
  - cin_train_o[i]=1 in CIN_TRAIN, WAIT_ALIGN, ALIGNING.
  - train_complete_o[i]=1 in COMPLETE, LIVE.
  - fail_o[i]=1 in FAIL.
- Timeout counter:
  - width $clog2(TIMEOUT_CYCLES);
  - clears on every state change;
  - increments only in CIN_TRAIN and COMPLETE;
  - saturates, never wraps.
- Arbiter:
  - Engine idle means align_req_o=0.
  - When idle, grant the first SURF in WAIT_ALIGN, searching upward from pointer+1 with wrap from 6 to 0.
  - In the grant cycle, load align_sel_o and set the pointer to the granted index.
  - align_req_o rises the cycle after grant and holds; align_sel_o stays stable while align_req_o=1.
  - align_req_o falls the cycle after align_done_i.
  - A new grant is allowed no earlier than the cycle after align_req_o falls, giving at least 1 idle cycle between requests.
  - align_done_i while align_req_o=0 is ignored.
- Abort during alignment:
  - The FSM goes to IDLE immediately.
  - align_req_o stays high until align_done_i; that result is discarded.
  - The SURF cannot be re-granted until the engine is idle.
- Simultaneous events: trainin_req_i fall and align_done_i in the same cycle resolve as abort, result discarded.

Optional Feature:
- Macro: SURF_AUTOTRAIN_RETRY_EN.
- When defined:
  - A per-SURF 2-bit retry counter is added.
  - align_ok_i=0 with retries < MAX_RETRY: increment the counter and return to WAIT_ALIGN. The SURF requeues behind the others via the round-robin pointer.
  - align_ok_i=0 with retries = MAX_RETRY: go to FAIL.
  - The counter clears on entry to IDLE.
- When not defined: any align_ok_i=0 goes directly to FAIL, and no retry logic is present.

Test Plan:
- Reset, then enable_i=7'h7F, trainin_req_i[0]=1: the cycle after, state_o[2:0]=1 and cin_train_o=7'h01. trainout_rdy_i[0]=1 gives WAIT_ALIGN, then align_req_o=1 with align_sel_o=0. align_done_i with align_ok_i=1 gives train_complete_o[0]=1 and cin_train_o[0]=0. surf_live_i[0]=1 gives state 5.
- SURFs 2, 5 and 6 enter WAIT_ALIGN in the same cycle: grants in order 2, 5, 6, with at least 1 idle cycle between align_req_o pulses. Then SURFs 6 and 0 wait after SURF 6 was last granted: SURF 0 granted first.
- TIMEOUT_CYCLES=16, trainout_rdy_i held 0: FAIL exactly 16 cycles after CIN_TRAIN entry and fail_o[i]=1. Dropping trainin_req_i returns to IDLE.
- SURF 3 ALIGNING, trainin_req_i[3] drops: state IDLE next cycle and cin_train_o[3]=0. align_req_o stays 1 until align_done_i (ok=1), which is then ignored: no train_complete_o.
- LIVE, surf_live_i drops: IDLE and train_complete_o=0. enable_i[i]=0 in any state forces IDLE within 1 cycle.
- align_ok_i=0: with SURF_AUTOTRAIN_RETRY_EN and MAX_RETRY=3, the 4th failure enters FAIL after 3 requeues. Without the macro, the 1st failure enters FAIL.
